// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match sequencer and the board/datapath side.
// The master side drives start/miss/hit; the slave side (the sequencer) drives everything else.
interface pong_match_ctrl_if;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       hit;
    logic       step;
    logic       engine_rst;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic [2:0] phase;

    modport master (
        output start, miss_left, miss_right, hit,
        input  step, engine_rst, serve_dir, score_left, score_right, game_over, phase
    );

    modport slave (
        input  start, miss_left, miss_right, hit,
        output step, engine_rst, serve_dir, score_left, score_right, game_over, phase
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: step prescaler, serve/point pauses, scoring and match end.
// Optional ball speedup on paddle hits is enabled by defining PONG_SPEEDUP_EN.
module pong_match_ctrl #(
    parameter int STEP_DIV    = 1000,
    parameter int SERVE_STEPS = 8,
    parameter int POINT_STEPS = 16,
    parameter int WIN_SCORE   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    pong_match_ctrl_if.slave  bus
);

    localparam int CW     = $clog2(STEP_DIV + 1);
    localparam int PMAX   = (SERVE_STEPS > POINT_STEPS) ? SERVE_STEPS : POINT_STEPS;
    localparam int PW     = $clog2(PMAX + 1);
    localparam logic [CW-1:0] PERIOD_RST = CW'(STEP_DIV);
    localparam logic [PW-1:0] SERVE_LAST = PW'(SERVE_STEPS - 1);
    localparam logic [PW-1:0] POINT_LAST = PW'(POINT_STEPS - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [PW-1:0] pause_cnt_q, pause_cnt_d;
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic          serve_dir_q, serve_dir_d;
    logic          step_q, step_d;
    logic          engine_rst_q, engine_rst_d;
    logic          game_over_q, game_over_d;
    logic          tick;

    // >= rather than == so a period that shrinks below the running count still wraps.
    assign tick = (div_cnt_q >= (period_q - CW'(1)));

`ifndef PONG_SPEEDUP_EN
    logic unused_hit;
    assign unused_hit = bus.hit;
`endif

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + CW'(1);
        period_d    = period_q;
        pause_cnt_d = pause_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        step_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (tick) begin
                    if (pause_cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else pause_cnt_d = pause_cnt_q + PW'(1);
                end
            end
            ST_PLAY: begin
                // A miss (including a draw) pre-empts any step in the same cycle.
                if (bus.miss_left && bus.miss_right) begin
                    state_d = ST_POINT;
                end else if (bus.miss_left) begin
                    if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (bus.miss_right) begin
                    if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end else begin
                    step_d = tick;
                end
`ifdef PONG_SPEEDUP_EN
                if (bus.hit) begin
                    if (period_q >= CW'(STEP_DIV >> 2) + CW'(STEP_DIV >> 3))
                        period_d = period_q - CW'(STEP_DIV >> 3);
                    else
                        period_d = CW'(STEP_DIV >> 2);
                end
`endif
            end
            ST_POINT: begin
                if (tick) begin
                    if (pause_cnt_q == POINT_LAST) begin
                        if (score_l_q == WIN || score_r_q == WIN) state_d = ST_GAME_OVER;
                        else state_d = ST_SERVE;
                    end else begin
                        pause_cnt_d = pause_cnt_q + PW'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (bus.start) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    state_d   = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) pause_cnt_d = '0;
        if (state_d == ST_SERVE && state_q != ST_SERVE) period_d = PERIOD_RST;

        engine_rst_d = (state_d != ST_PLAY);
        game_over_d  = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            period_q     <= PERIOD_RST;
            pause_cnt_q  <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_dir_q  <= 1'b0;
            step_q       <= 1'b0;
            engine_rst_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            period_q     <= period_d;
            pause_cnt_q  <= pause_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_dir_q  <= serve_dir_d;
            step_q       <= step_d;
            engine_rst_q <= engine_rst_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.step        = step_q;
    assign bus.engine_rst  = engine_rst_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.score_left  = score_l_q;
    assign bus.score_right = score_r_q;
    assign bus.game_over   = game_over_q;
    assign bus.phase       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with STEP_DIV=8, SERVE_STEPS=2, POINT_STEPS=2, WIN_SCORE=3.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;

`ifdef PONG_SPEEDUP_EN
    localparam int EXP_P1    = 7;
    localparam int EXP_FLOOR = 2;
`else
    localparam int EXP_P1    = 8;
    localparam int EXP_FLOOR = 8;
`endif

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .STEP_DIV    (8),
        .SERVE_STEPS (2),
        .POINT_STEPS (2),
        .WIN_SCORE   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] ph, output int cnt);
        logic seen = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc();
            cnt++;
            if (bus.phase == ph) seen = 1'b1;
        end
        check($sformatf("reach_phase_%0d", ph), 32'(seen), 32'd1);
    endtask

    task automatic wait_step(output int cnt);
        logic seen = 1'b0;
        cnt = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            cnt++;
            if (bus.step) seen = 1'b1;
        end
        check("step_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_phase"},      32'(bus.phase),       32'd0);
        check({pfx, "_step"},       32'(bus.step),        32'd0);
        check({pfx, "_engine_rst"}, 32'(bus.engine_rst),  32'd1);
        check({pfx, "_serve_dir"},  32'(bus.serve_dir),   32'd0);
        check({pfx, "_score_l"},    32'(bus.score_left),  32'd0);
        check({pfx, "_score_r"},    32'(bus.score_right), 32'd0);
        check({pfx, "_game_over"},  32'(bus.game_over),   32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.miss_left = 1'b0; bus.miss_right = 1'b0; bus.hit = 1'b0;
        rst_n = 1'b0;
        #20;
        check_reset_outputs("rst");
        #2 rst_n = 1'b1;

        // Edges 8, 16, 24 ... are tick edges; start is sampled at edge 8.
        repeat (7) cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("serve_phase", 32'(bus.phase), 32'd1);
        check("serve_engine_rst", 32'(bus.engine_rst), 32'd1);
        wait_phase(3'd2, n);
        check("serve_len", 32'(n), 32'd16);
        check("play_engine_rst", 32'(bus.engine_rst), 32'd0);
        wait_step(n);
        check("first_step", 32'(n), 32'd8);
        wait_step(n);
        check("step_period", 32'(n), 32'd8);
        cyc();
        check("step_single", 32'(bus.step), 32'd0);

        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("start_ignored", 32'(bus.phase), 32'd2);

        bus.miss_left = 1'b1;
        cyc();
        bus.miss_left = 1'b0;
        check("ml_score_r", 32'(bus.score_right), 32'd1);
        check("ml_score_l", 32'(bus.score_left), 32'd0);
        check("ml_dir", 32'(bus.serve_dir), 32'd0);
        check("ml_phase", 32'(bus.phase), 32'd3);
        check("ml_engine_rst", 32'(bus.engine_rst), 32'd1);
        wait_phase(3'd1, n);
        check("point_len", 32'(n), 32'd13);

        wait_phase(3'd2, n);
        bus.miss_right = 1'b1;
        cyc();
        bus.miss_right = 1'b0;
        check("mr_score_l", 32'(bus.score_left), 32'd1);
        check("mr_dir", 32'(bus.serve_dir), 32'd1);
        check("mr_phase", 32'(bus.phase), 32'd3);

        wait_phase(3'd2, n);
        bus.miss_left = 1'b1; bus.miss_right = 1'b1;
        cyc();
        bus.miss_left = 1'b0; bus.miss_right = 1'b0;
        check("draw_score_l", 32'(bus.score_left), 32'd1);
        check("draw_score_r", 32'(bus.score_right), 32'd1);
        check("draw_dir", 32'(bus.serve_dir), 32'd1);
        check("draw_phase", 32'(bus.phase), 32'd3);

        // Miss lands exactly on the next tick edge after a step.
        wait_phase(3'd2, n);
        wait_step(n);
        repeat (7) cyc();
        bus.miss_right = 1'b1;
        cyc();
        bus.miss_right = 1'b0;
        check("tick_miss_step", 32'(bus.step), 32'd0);
        check("tick_miss_phase", 32'(bus.phase), 32'd3);
        check("tick_miss_score_l", 32'(bus.score_left), 32'd2);

        wait_phase(3'd2, n);
        bus.miss_right = 1'b1;
        cyc();
        bus.miss_right = 1'b0;
        check("win_score_l", 32'(bus.score_left), 32'd3);
        wait_phase(3'd4, n);
        check("go_flag", 32'(bus.game_over), 32'd1);
        check("go_engine_rst", 32'(bus.engine_rst), 32'd1);
        bus.miss_left = 1'b1;
        cyc();
        bus.miss_left = 1'b0; bus.miss_right = 1'b1;
        cyc();
        bus.miss_right = 1'b0;
        cyc();
        check("go_hold_l", 32'(bus.score_left), 32'd3);
        check("go_hold_r", 32'(bus.score_right), 32'd1);
        check("go_hold_phase", 32'(bus.phase), 32'd4);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("restart_phase", 32'(bus.phase), 32'd1);
        check("restart_l", 32'(bus.score_left), 32'd0);
        check("restart_r", 32'(bus.score_right), 32'd0);
        check("restart_go", 32'(bus.game_over), 32'd0);

        // Speedup: one hit, then six more reaching the floor.
        wait_phase(3'd2, n);
        wait_step(n);
        bus.hit = 1'b1;
        cyc();
        bus.hit = 1'b0;
        wait_step(n);
        check("hit1_period", 32'(n + 1), 32'(EXP_P1));
        wait_step(n);
        check("hit1_steady", 32'(n), 32'(EXP_P1));
        for (int i = 0; i < 6; i++) begin
            bus.hit = 1'b1;
            cyc();
        end
        bus.hit = 1'b0;
        wait_step(n);
        wait_step(n);
        check("hit7_floor", 32'(n), 32'(EXP_FLOOR));

        bus.miss_left = 1'b1;
        cyc();
        bus.miss_left = 1'b0;
        wait_phase(3'd2, n);
        wait_step(n);
        wait_step(n);
        check("period_restored", 32'(n), 32'd8);

        for (int r = 0; r < 2; r++) begin
            wait_phase(3'd2, n);
            bus.miss_right = 1'b1;
            cyc();
            bus.miss_right = 1'b0;
        end
        check("pre_rst_score_l", 32'(bus.score_left), 32'd2);
        wait_phase(3'd2, n);
        cyc();
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #10 rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
